// File: rtl/adder.sv
// Registered WORD-bit two's-complement adder (A + B + cin) with NZCV flags and a valid qualifier.
// Latency: 1 cycle from an in_valid edge to add_out/flags/out_valid; one add per cycle.
// Backpressure: none; every in_valid cycle yields exactly one out_valid cycle, and idle cycles hold the last result.
module adder #(
    parameter int WORD = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [WORD-1:0] Ain,
    input  logic [WORD-1:0] Bin,
    input  logic            cin,
    output logic [WORD-1:0] add_out,
    output logic            out_valid,
    output logic            flag_n,
    output logic            flag_z,
    output logic            flag_c,
    output logic            flag_v
);

    // Carry tree: 4-bit groups, 4 groups per 16-bit block, and a flat
    // lookahead across blocks. Operands are zero-padded up to a whole number
    // of blocks; padded bits neither generate nor propagate, so the carry
    // into bit WORD is the true carry out of the MSB.
    localparam int NBLK = (WORD + 15) / 16;
    localparam int NGRP = NBLK * 4;
    localparam int PW   = NBLK * 16;

    // Group generate from four generate bits and the upper three propagates.
    function automatic logic grp_gen(input logic [3:0] g, input logic [2:0] p_hi);
        return g[3]
             | (p_hi[2] & g[2])
             | (p_hi[2] & p_hi[1] & g[1])
             | (p_hi[2] & p_hi[1] & p_hi[0] & g[0]);
    endfunction

    // Carries into positions 0..3 of a 4-wide group, each in two-level form.
    function automatic logic [3:0] grp_carry(input logic [2:0] g, input logic [2:0] p,
                                             input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    logic [PW-1:0]   a_pad;
    logic [PW-1:0]   b_pad;
    logic [PW-1:0]   bit_g;
    logic [PW-1:0]   bit_p;
    logic [NGRP-1:0] grp_g;
    logic [NGRP-1:0] grp_p;
    logic [NBLK-1:0] blk_g;
    logic [NBLK-1:0] blk_p;
    logic [NBLK:0]   blk_c;
    logic [NGRP-1:0] grp_c;
    logic [PW:0]     carry;
    logic [PW-1:0]   sum_pad;
    logic            lk_acc;
    logic            lk_term;

    logic [WORD-1:0] sum;
    logic            c_out;
    logic            n_nxt;
    logic            z_nxt;
    logic            v_nxt;

    assign a_pad = PW'(Ain);
    assign b_pad = PW'(Bin);
    assign bit_g = a_pad & b_pad;
    assign bit_p = a_pad ^ b_pad;

    // Level 1: generate/propagate of each 4-bit group.
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int gi = 0; gi < NGRP; gi++) begin
            grp_g[gi] = grp_gen(bit_g[gi*4 +: 4], bit_p[gi*4+1 +: 3]);
            grp_p[gi] = &bit_p[gi*4 +: 4];
        end
    end

    // Level 2: generate/propagate of each 16-bit block from its four groups.
    always_comb begin
        blk_g = '0;
        blk_p = '0;
        for (int bi = 0; bi < NBLK; bi++) begin
            blk_g[bi] = grp_gen(grp_g[bi*4 +: 4], grp_p[bi*4+1 +: 3]);
            blk_p[bi] = &grp_p[bi*4 +: 4];
        end
    end

    // Level 3: carry into every block as an independent sum of products, so
    // no block waits on the block below it.
    always_comb begin
        blk_c   = '0;
        lk_acc  = 1'b0;
        lk_term = 1'b0;
        blk_c[0] = cin;
        for (int k = 1; k <= NBLK; k++) begin
            lk_term = cin;
            for (int j = 0; j < k; j++) begin
                lk_term = lk_term & blk_p[j];
            end
            lk_acc = lk_term;
            for (int i = 0; i < k; i++) begin
                lk_term = blk_g[i];
                for (int j = i + 1; j < k; j++) begin
                    lk_term = lk_term & blk_p[j];
                end
                lk_acc = lk_acc | lk_term;
            end
            blk_c[k] = lk_acc;
        end
    end

    // Distribute block carries down to the groups inside each block.
    always_comb begin
        grp_c = '0;
        for (int bi = 0; bi < NBLK; bi++) begin
            grp_c[bi*4 +: 4] = grp_carry(grp_g[bi*4 +: 3], grp_p[bi*4 +: 3], blk_c[bi]);
        end
    end

    // Distribute group carries down to the bits; the top carry is the block-level carry out.
    always_comb begin
        carry = '0;
        for (int gi = 0; gi < NGRP; gi++) begin
            carry[gi*4 +: 4] = grp_carry(bit_g[gi*4 +: 3], bit_p[gi*4 +: 3], grp_c[gi]);
        end
        carry[PW] = blk_c[NBLK];
    end

    assign sum_pad = bit_p ^ carry[PW-1:0];
    assign sum     = sum_pad[WORD-1:0];
    assign c_out   = carry[WORD];

    // Flags derive from the very sum that gets registered.
    assign n_nxt = sum[WORD-1];
    assign z_nxt = ~|sum;
    assign v_nxt = (Ain[WORD-1] == Bin[WORD-1]) && (sum[WORD-1] != Ain[WORD-1]);

    // Output register: capture on in_valid, otherwise hold data and drop valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            add_out   <= '0;
            out_valid <= 1'b0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
        end else if (in_valid) begin
            add_out   <= sum;
            out_valid <= 1'b1;
            flag_n    <= n_nxt;
            flag_z    <= z_nxt;
            flag_c    <= c_out;
            flag_v    <= v_nxt;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder at WORD=64 and WORD=32.
// Directed table, hand-written multi-cycle sequences, then a randomized sweep.
// Inputs are driven 1 time unit after the rising edge; outputs are checked at the same point.
module tb_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset    = 1'b0;
    logic        in_valid = 1'b0;
    logic        cin      = 1'b0;
    logic [63:0] a64      = '0;
    logic [63:0] b64      = '0;
    logic [31:0] a32      = '0;
    logic [31:0] b32      = '0;

    logic [63:0] s64;
    logic        vld64, n64, z64, c64, v64;
    logic [31:0] s32;
    logic        vld32, n32, z32, c32, v32;

    adder #(.WORD(64)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .Ain(a64), .Bin(b64), .cin(cin),
        .add_out(s64), .out_valid(vld64), .flag_n(n64), .flag_z(z64), .flag_c(c64), .flag_v(v64)
    );

    adder #(.WORD(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .Ain(a32), .Bin(b32), .cin(cin),
        .add_out(s32), .out_valid(vld32), .flag_n(n32), .flag_z(z32), .flag_c(c32), .flag_v(v32)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [63:0] sum;
        logic        vld, n, z, c, v;
    } r64_t;

    typedef struct packed {
        logic [31:0] sum;
        logic        vld, n, z, c, v;
    } r32_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        ci;
        logic [63:0] sum;
        logic        n, z, c, v;
    } vec_t;

    vec_t vecs[10];

    // Reference: plain wide arithmetic plus the flag definitions.
    function automatic r64_t model64(input logic [63:0] a, input logic [63:0] b, input logic ci);
        logic [64:0] w;
        r64_t r;
        w = {1'b0, a} + {1'b0, b} + {64'd0, ci};
        r.sum = w[63:0];
        r.vld = 1'b1;
        r.n   = w[63];
        r.z   = (w[63:0] == 64'd0);
        r.c   = w[64];
        r.v   = (a[63] == b[63]) && (w[63] != a[63]);
        return r;
    endfunction

    function automatic r32_t model32(input logic [31:0] a, input logic [31:0] b, input logic ci);
        logic [32:0] w;
        r32_t r;
        w = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        r.sum = w[31:0];
        r.vld = 1'b1;
        r.n   = w[31];
        r.z   = (w[31:0] == 32'd0);
        r.c   = w[32];
        r.v   = (a[31] == b[31]) && (w[31] != a[31]);
        return r;
    endfunction

    task automatic check64(input string nm, input r64_t exp);
        r64_t got;
        got = {s64, vld64, n64, z64, c64, v64};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got sum=%h vld=%b nzcv=%b%b%b%b, expected sum=%h vld=%b nzcv=%b%b%b%b",
                     nm, got.sum, got.vld, got.n, got.z, got.c, got.v,
                     exp.sum, exp.vld, exp.n, exp.z, exp.c, exp.v);
        end
    endtask

    task automatic check32(input string nm, input r32_t exp);
        r32_t got;
        got = {s32, vld32, n32, z32, c32, v32};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got sum=%h vld=%b nzcv=%b%b%b%b, expected sum=%h vld=%b nzcv=%b%b%b%b",
                     nm, got.sum, got.vld, got.n, got.z, got.c, got.v,
                     exp.sum, exp.vld, exp.n, exp.z, exp.c, exp.v);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b, input logic ci);
        in_valid = v;
        a64      = a;
        b64      = b;
        cin      = ci;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        r64_t  m64;
        r32_t  m32;
        logic  v;
        logic [63:0] ra, rb;
        logic  rc;
        int    sel;

        vecs[0] = '{64'd5,                  64'd100,                0, 64'd105,                0, 0, 0, 0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 0, 64'd0,                  0, 1, 1, 0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                 0, 64'h8000_0000_0000_0000, 1, 0, 0, 1};
        vecs[3] = '{64'd0,                  64'd0,                  1, 64'd1,                  0, 0, 0, 0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 64'd0,                0, 1, 1, 1};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 1, 0};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                 1, 64'd0,                  0, 1, 1, 0};
        vecs[7] = '{64'h0000_0000_0000_FFFF, 64'd1,                 0, 64'h0000_0000_0001_0000, 0, 0, 0, 0};
        vecs[8] = '{64'h0000_0000_FFFF_FFFF, 64'd1,                 0, 64'h0000_0001_0000_0000, 0, 0, 0, 0};
        vecs[9] = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1, 64'd0,                0, 1, 1, 0};

        // Reset state, asserted between clock edges.
        #1 reset = 1'b1;
        #2;
        check64("reset_state_64", '0);
        check32("reset_state_32", '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].ci);
            tick();
            check64($sformatf("vec%0d", i), {vecs[i].sum, 1'b1, vecs[i].n, vecs[i].z, vecs[i].c, vecs[i].v});
        end

        // PC increment stream: back-to-back valid results.
        drive(1'b1, 64'h1000, 64'd4, 1'b0);
        tick();
        check64("pc_stream0", {64'h1004, 5'b1_0000});
        drive(1'b1, 64'h1004, 64'd4, 1'b0);
        tick();
        check64("pc_stream1", {64'h1008, 5'b1_0000});
        drive(1'b1, 64'h1008, 64'd4, 1'b0);
        tick();
        check64("pc_stream2", {64'h100C, 5'b1_0000});

        // Hold: idle cycles keep the result and drop valid.
        drive(1'b1, 64'd7, 64'd8, 1'b0);
        tick();
        check64("hold_load", {64'd15, 5'b1_0000});
        drive(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1);
        tick();
        check64("hold_idle0", {64'd15, 5'b0_0000});
        drive(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        tick();
        check64("hold_idle1", {64'd15, 5'b0_0000});

        // Async reset mid-cycle, held across an edge with in_valid, then recovery.
        drive(1'b1, 64'd5, 64'd100, 1'b0);
        tick();
        check64("pre_reset", {64'd105, 5'b1_0000});
        drive(1'b1, 64'd9, 64'd9, 1'b0);
        #2 reset = 1'b1;
        #1;
        check64("async_reset", '0);
        tick();
        check64("reset_held", '0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 64'd9, 64'd9, 1'b0);
        tick();
        check64("post_reset_idle", '0);
        drive(1'b1, 64'd1, 64'd2, 1'b0);
        tick();
        check64("post_reset_first", {64'd3, 5'b1_0000});

        // Randomized sweep on both widths against the arithmetic model.
        m64 = '0;
        m32 = '0;
        for (int i = 0; i < 10000; i++) begin
            v   = (i == 0) ? 1'b1 : ($urandom_range(0, 9) != 0);
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            rc  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            case (sel)
                0: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                1: ra = 64'h7FFF_FFFF_FFFF_FFFF;
                2: rb = ~ra;
                3: rb = 64'h8000_0000_8000_0000;
                default: ;
            endcase
            drive(v, ra, rb, rc);
            a32 = ra[31:0];
            b32 = rb[63:32];
            if (sel == 2) b32 = ~a32;
            if (v) begin
                m64 = model64(ra, rb, rc);
                m32 = model32(a32, b32, rc);
            end else begin
                m64.vld = 1'b0;
                m32.vld = 1'b0;
            end
            tick();
            check64($sformatf("rand64_%0d", i), m64);
            check32($sformatf("rand32_%0d", i), m32);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder.md
# adder

Registered WORD-bit two's-complement adder for the fetch stage: computes Ain + Bin (+ carry-in) and presents the sum and NZCV flags one clock later. Its primary use is the PC incrementer (PC + 4) and the branch-target adder (PC + offset). Because it is a single shared arithmetic primitive, it is pipelined with a valid qualifier so downstream logic can tell fresh results from stale ones.

## Interface

- Clocking: one clock (`clk`); reset `reset` is asynchronous and active-high.
- Parameter `WORD`, default 64 (the `WORD` definition): operand and result width in bits.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high; clears all registers.
- `in_valid`, input, 1: operands on Ain/Bin/cin are valid this cycle.
- `Ain`, input, WORD: operand A.
- `Bin`, input, WORD: operand B.
- `cin`, input, 1: carry-in (0 for normal add).
- `add_out`, output, WORD: registered sum.
- `out_valid`, output, 1: add_out/flags hold a result computed from an in_valid cycle.
- `flag_n`, output, 1: add_out[WORD-1].
- `flag_z`, output, 1: add_out == 0.
- `flag_c`, output, 1: carry out of bit WORD-1.
- `flag_v`, output, 1: signed overflow.

## Operation

- Sum: {carry, sum} = Ain + Bin + cin, computed in WORD+1 bits. add_out gets the low WORD bits, so results wrap modulo 2^WORD.
- Carry path: WORD-bit carry-lookahead built from 4-bit generate/propagate groups with a second-level group lookahead. A plain ripple chain is not acceptable. The result must be bit-exact to the behavioural sum.
- flag_c = carry out of MSB.
- flag_v = (Ain[MSB] == Bin[MSB]) && (sum[MSB] != Ain[MSB]).
- flag_n = sum[MSB].
- flag_z = (sum == 0).
- Flags are computed from the same sum that is registered into add_out.
- When in_valid = 1, the sum, flags and out_valid = 1 are registered on the rising edge of clk.
- When in_valid = 0, add_out and the flags hold their previous values, and out_valid is registered as 0.
- No internal state beyond the output registers. There is no backpressure: every accepted operand pair produces exactly one result.

## Timing

- Latency is 1 cycle: operands sampled at edge k appear on the outputs after edge k, and are readable for the cycle k→k+1.
- Throughput is one add per cycle. Back-to-back in_valid produces back-to-back out_valid.
- While reset = 1, immediately and independent of clk: add_out = 0, flag_n = 0, flag_z = 0, flag_c = 0, flag_v = 0, out_valid = 0.
- Reset asserted mid-operation discards any in-flight result. The first result after reset release is from the first in_valid sampled on an edge where reset = 0.
- The combinational path Ain/Bin/cin → register must close at the target clock with WORD = 64.

## Test plan

- Basic add: Ain = 5, Bin = 100, cin = 0, in_valid = 1 → the next cycle shows add_out = 105, out_valid = 1, N = 0, Z = 0, C = 0, V = 0.
- PC increment stream: Ain = 0x1000, 0x1004, 0x1008 with Bin = 4 on consecutive cycles → add_out = 0x1004, 0x1008, 0x100C on consecutive cycles, with out_valid held at 1.
- Wrap and zero: Ain = 0xFFFF_FFFF_FFFF_FFFF, Bin = 1 → add_out = 0, Z = 1, C = 1, V = 0, N = 0.
- Signed overflow: Ain = 0x7FFF_FFFF_FFFF_FFFF, Bin = 1 → add_out = 0x8000_0000_0000_0000, N = 1, V = 1, C = 0. Carry-in: Ain = 0, Bin = 0, cin = 1 → add_out = 1.
- Hold: valid add of 7 + 8, then in_valid = 0 with changing operands → add_out stays 15 and out_valid drops to 0.
- Async reset: assert reset between clock edges while add_out = 105 → add_out = 0, out_valid = 0 and all flags = 0 immediately. Random sweep of 10k operand pairs with WORD = 64 and WORD = 32 → matches the behavioural WORD+1-bit sum.
